// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned WIDTH_MIN = 2;
  localparam int unsigned WIDTH_MAX = 32;

  function automatic int unsigned cnt_width(input int unsigned w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_add_bit.sv
// Combinational full-adder bit cell assembled from two half-add stages.
module serial_add_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p, g1, g2;

  assign p    = a ^ b;
  assign g1   = a & b;
  assign s    = p ^ cin;
  assign g2   = p & cin;
  assign cout = g1 | g2;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one bit cell time-shared over WIDTH bits, LSB first.
// Define SERIAL_ADD_SUB_EN to add the Sub port and two's-complement subtraction.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             Sub,
`endif
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);

  localparam int unsigned CW = cnt_width(WIDTH);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("serial_add_ctrl: WIDTH out of range");
  end

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             b_bit;
  logic             s_bit;
  logic             c_bit;

`ifdef SERIAL_ADD_SUB_EN
  logic sub_q;
  assign b_bit = b_q[0] ^ sub_q;
`else
  assign b_bit = b_q[0];
`endif

  serial_add_bit u_bit (
    .a    (a_q[0]),
    .b    (b_bit),
    .cin  (carry),
    .s    (s_bit),
    .cout (c_bit)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      Busy  <= 1'b0;
      Done  <= 1'b0;
      Sum   <= '0;
      Cout  <= 1'b0;
`ifdef SERIAL_ADD_SUB_EN
      sub_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          Done <= 1'b0;
          if (Start) begin
            a_q   <= A;
            b_q   <= B;
            cnt   <= '0;
`ifdef SERIAL_ADD_SUB_EN
            sub_q <= Sub;
            carry <= Sub;
`else
            carry <= 1'b0;
`endif
            Busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          // Result enters from the MSB so that after WIDTH shifts bit 0 lands at Sum[0].
          Sum   <= {s_bit, Sum[WIDTH-1:1]};
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          carry <= c_bit;
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            Cout  <= c_bit;
            Busy  <= 1'b0;
            Done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          Done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          Busy  <= 1'b0;
          Done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl (WIDTH=8); Sub tests need SERIAL_ADD_SUB_EN.
module tb_serial_add_ctrl;

  localparam int unsigned W = 8;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
  } exp_t;

  logic         Clk = 1'b0;
  logic         Rst = 1'b1;
  logic         Start = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         Sub = 1'b0;
  logic         Busy, Done, Cout;
  logic [W-1:0] Sum;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  exp_t        exp_q[$];

  serial_add_ctrl #(.WIDTH(W)) dut (
    .Clk   (Clk),
    .Rst   (Rst),
    .Start (Start),
    .A     (A),
    .B     (B),
`ifdef SERIAL_ADD_SUB_EN
    .Sub   (Sub),
`endif
    .Busy  (Busy),
    .Done  (Done),
    .Sum   (Sum),
    .Cout  (Cout)
  );

  always #5 Clk = ~Clk;

  // Result checker: every Done pulse consumes one expected entry.
  always @(negedge Clk) begin
    if (Done === 1'b1) begin
      exp_t e;
      vectors++;
      if (Busy !== 1'b0) begin
        miscompares++;
        $display("FAIL busy_with_done: Busy=%b required 0", Busy);
      end
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_done: Sum=%h Cout=%b, no result expected", Sum, Cout);
      end else begin
        e = exp_q.pop_front();
        if (Sum !== e.sum || Cout !== e.cout) begin
          miscompares++;
          $display("FAIL result: Sum=%h Cout=%b required Sum=%h Cout=%b", Sum, Cout, e.sum, e.cout);
        end
      end
    end
  end

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    logic [W:0]   full;
    logic [W-1:0] bb;
    logic         cin;
    exp_t         e;
`ifdef SERIAL_ADD_SUB_EN
    bb  = sub ? ~b : b;
    cin = sub;
`else
    bb  = b;
    cin = 1'b0;
    if (sub) bb = b;
`endif
    full   = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, cin};
    e.sum  = full[W-1:0];
    e.cout = full[W];
    return e;
  endfunction

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    int unsigned n = 0;
    int unsigned busy_cycles = 0;
    exp_q.push_back(model(a, b, sub));
    @(negedge Clk);
    A = a; B = b; Sub = sub; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0; A = $urandom; B = $urandom; Sub = $urandom;
    while (Done !== 1'b1 && n < 4 * W) begin
      if (Busy === 1'b1) busy_cycles++;
      @(negedge Clk);
      n++;
    end
    vectors++;
    if (n !== W) begin
      miscompares++;
      $display("FAIL latency: Done after %0d cycles required %0d", n, W);
    end
    vectors++;
    if (busy_cycles !== W) begin
      miscompares++;
      $display("FAIL busy_length: Busy for %0d cycles required %0d", busy_cycles, W);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge Clk);
    vectors++;
    if (Busy !== 1'b0 || Done !== 1'b0 || Sum !== '0 || Cout !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: Busy=%b Done=%b Sum=%h Cout=%b required 0 0 00 0", Busy, Done, Sum, Cout);
    end
    Rst = 1'b0;
  endtask

  task automatic test_add();
    do_op(8'h5A, 8'h3C, 1'b0);
  endtask

  task automatic test_carry();
    do_op(8'hFF, 8'h01, 1'b0);
  endtask

  task automatic test_back_to_back();
    int unsigned ndone = 0;
    int          last = -1;
    int          want;
    for (int i = 0; i < 4; i++) exp_q.push_back(model(8'h01, 8'h02, 1'b0));
    @(negedge Clk);
    A = 8'h01; B = 8'h02; Sub = 1'b0; Start = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge Clk);
      if (Done === 1'b1) begin
        want = (ndone == 0) ? W : last + W + 2;
        vectors++;
        if (k !== want) begin
          miscompares++;
          $display("FAIL b2b_spacing: Done at cycle %0d required %0d", k, want);
        end
        last = k;
        ndone++;
      end
    end
    Start = 1'b0;
    vectors++;
    if (ndone !== 4) begin
      miscompares++;
      $display("FAIL b2b_count: %0d Done pulses required 4", ndone);
    end
  endtask

  task automatic test_ignore_start();
    int unsigned n = 0;
    bit          busy_seen = 0;
    exp_q.push_back(model(8'h11, 8'h22, 1'b0));
    @(negedge Clk);
    A = 8'h11; B = 8'h22; Sub = 1'b0; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    repeat (3) begin @(negedge Clk); n++; end
    A = 8'hAA; Start = 1'b1;
    @(negedge Clk); n++;
    Start = 1'b0;
    while (Done !== 1'b1 && n < 4 * W) begin @(negedge Clk); n++; end
    vectors++;
    if (n !== W) begin
      miscompares++;
      $display("FAIL ignore_latency: Done after %0d cycles required %0d", n, W);
    end
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    repeat (12) begin
      @(negedge Clk);
      if (Busy !== 1'b0) busy_seen = 1;
    end
    vectors++;
    if (busy_seen) begin
      miscompares++;
      $display("FAIL start_in_done: Busy went high, required 0");
    end
    vectors++;
    if (Sum !== 8'h33 || Cout !== 1'b0) begin
      miscompares++;
      $display("FAIL hold: Sum=%h Cout=%b required 33 0", Sum, Cout);
    end
  endtask

  task automatic test_reset_abort();
    @(negedge Clk);
    A = 8'h5A; B = 8'h3C; Sub = 1'b0; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    repeat (4) @(negedge Clk);
    vectors++;
    if (Busy !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_pre: Busy=%b required 1", Busy);
    end
    Rst = 1'b1;
    #1;
    vectors++;
    if (Busy !== 1'b0 || Done !== 1'b0 || Sum !== '0 || Cout !== 1'b0) begin
      miscompares++;
      $display("FAIL abort: Busy=%b Done=%b Sum=%h Cout=%b required 0 0 00 0", Busy, Done, Sum, Cout);
    end
    repeat (2) @(negedge Clk);
    Rst = 1'b0;
    repeat (12) @(negedge Clk);
    do_op(8'h5A, 8'h3C, 1'b0);
  endtask

  task automatic test_sub();
`ifdef SERIAL_ADD_SUB_EN
    do_op(8'h10, 8'h20, 1'b1);
    do_op(8'h20, 8'h10, 1'b1);
    do_op(8'h37, 8'h37, 1'b1);
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
`ifdef SERIAL_ADD_SUB_EN
      do_op(W'($urandom), W'($urandom), 1'($urandom));
`else
      do_op(W'($urandom), W'($urandom), 1'b0);
`endif
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_carry();
    test_reset_abort();
    test_back_to_back();
    test_ignore_start();
    test_sub();
    test_random();
    repeat (4) @(negedge Clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL missing_done: %0d results outstanding required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial adder controller that sequences a single one-bit add cell over two WIDTH-bit operands, least-significant bit first, under a Start/Busy/Done handshake. It time-shares one bit cell in place of a WIDTH-bit parallel adder, trading latency for area. It sits between a requesting master, which supplies operands and a start pulse, and any consumer of the registered Sum/Cout result.

## Interface
- WIDTH, 8, operand and result width in bits; legal range 2..32.
- Clk  input  1  single clock; all state updates on the rising edge.
- Rst  input  1  asynchronous, active-high reset.
- Start  input  1  request; sampled only in IDLE.
- A  input  WIDTH  operand A; captured on the accepting edge.
- B  input  WIDTH  operand B; captured on the accepting edge.
- Sub  input  1  subtract select; present only with SERIAL_ADD_SUB_EN; captured with the operands.
- Busy  output  1  high while the block is in RUN.
- Done  output  1  one-cycle pulse in DONE; Sum and Cout are valid.
- Sum  output  WIDTH  registered result.
- Cout  output  1  registered final carry.

## Operation
- States:
  - IDLE: wait for a request.
  - RUN: process one bit per cycle.
  - DONE: one-cycle completion pulse, then return to IDLE.
- IDLE with Start=1 at an edge:
  - Capture A and B into shift registers.
  - Capture Sub, if present.
  - Clear bit counter cnt to 0.
  - Set the carry flop to Sub (0 without the macro).
  - Go to RUN.
- RUN, each edge:
  - Bit cell computes s = a0 ^ b0' ^ c and c' = a0&b0' | (a0^b0')&c.
  - b0' = b0 ^ Sub.
  - Shift s into the result register from the MSB side; shift A and B right by one.
  - Update carry; increment cnt.
  - When cnt == WIDTH-1, go to DONE.
- DONE:
  - Done=1 for exactly one cycle; Cout = carry.
  - Next edge goes to IDLE.
- Sum/Cout hold their value from DONE until the next accepted Start.
- Arithmetic is modulo 2^WIDTH:
  - Add: Cout is the carry out of the MSB.
  - Subtract: Cout=1 means A >= B (no borrow).
- Start is ignored in RUN and DONE; it is not queued.

## Timing
- Reset values:
  - State: IDLE.
  - Busy=0, Done=0, Sum=0, Cout=0.
  - cnt=0, carry=0.
  - Operand registers: 0.
- Rst asserted mid-RUN or in DONE aborts immediately. No Done pulse is issued, and the partial result is cleared.
- Latency: Start accepted at edge 0; RUN spans edges 1..WIDTH; Done is high in the cycle following edge WIDTH.
- Busy is high from after edge 0 through edge WIDTH.
- Start held high continuously gives back-to-back operations, one accepted every WIDTH+2 cycles.
- A, B and Sub may change freely after the accepting edge.
- Done and Busy are never high in the same cycle.

## Configuration
- SERIAL_ADD_SUB_EN defined:
  - The Sub port exists.
  - Subtract inverts B bits and seeds carry-in to 1.
- Not defined:
  - No Sub port.
  - Carry-in is always 0; add-only.
  - The inversion XOR is removed.

## Structure
- Package serial_add_pkg holds:
  - State typedef (IDLE, RUN, DONE; 2-bit encoding).
  - Width-limit constants.
  - Counter-width function ($clog2(WIDTH)).
- Sub-module serial_add_bit: combinational full-adder bit cell built from two half-add stages. It is instantiated once; the FSM, counter and shift registers stay in serial_add_ctrl.

## Test plan
- WIDTH=8, A=0x5A, B=0x3C, Start pulse -> Done exactly 8 cycles after accept; Sum=0x96, Cout=0.
- A=0xFF, B=0x01 -> Sum=0x00, Cout=1. Busy high for 8 cycles, then Done for 1 cycle.
- Start held high for 40 cycles with A=0x01, B=0x02 -> Done pulses every 10 cycles, each with Sum=0x03, Cout=0.
- Start re-pulsed with A=0xAA during RUN of 0x11+0x22 -> ignored; result Sum=0x33.
- Rst asserted 4 cycles into RUN -> Busy=0, Sum=0, Cout=0 immediately; no Done pulse; a new Start after release works normally.
- With SERIAL_ADD_SUB_EN: Sub=1, A=0x10, B=0x20 -> Sum=0xF0, Cout=0. Sub=1, A=0x20, B=0x10 -> Sum=0x10, Cout=1.
